// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer
//   Sole owner of the external SRAM control pins. Arbitrates single-byte accesses
//   between acquisition writes, MCU data-register writes and MCU data-register reads
//   (fixed priority in that order), sequences WE_n/OE_n and the data-bus turnaround,
//   captures read data and pulses the address-counter increment after each access.
//
//   Ports
//     CLOCK, RESET                  clock, synchronous active-high reset
//     ACQ_WR_REQ/ACQ_WR_DATA        acquisition byte request + data
//     ACQ_ABORT                     discard a pending acquisition write
//     MCU_WR_REQ/MCU_WR_DATA        MCU write request + data
//     MCU_RD_REQ                    MCU read request
//     SRAM_FULL                     address counter full flag
//     SRAM_DQ_IN/OUT/OE             SRAM data bus in, out, output enable
//     SRAM_WE_n, SRAM_OE_n          SRAM strobes (active low)
//     ADDR_INC                      one-cycle address increment
//     RD_DATA, RD_VALID             last read byte, update pulse
//     BUSY                          access in flight or pending
//     ACQ_OVERRUN                   sticky acquisition byte loss
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | OE_n low, bus released; grant taken here
//   W_SETUP  | OE_n high, bus released for turnaround; DQ_OUT loaded
//   W_PULSE  | WE_n low for WE_CYCLES, bus driven
//   W_HOLD   | WE_n high, data still driven
//   R_SETUP  | read granted, OE_n low
//   R_WAIT   | OE_n low for RD_CYCLES, data sampled on last cycle
//   INC      | address increment (and RD_VALID after a read)
module sram_access_sequencer #(
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       ACQ_WR_REQ,
    input  logic [7:0] ACQ_WR_DATA,
    input  logic       ACQ_ABORT,
    input  logic       MCU_WR_REQ,
    input  logic [7:0] MCU_WR_DATA,
    input  logic       MCU_RD_REQ,
    input  logic       SRAM_FULL,
    input  logic [7:0] SRAM_DQ_IN,
    output logic [7:0] SRAM_DQ_OUT,
    output logic       SRAM_DQ_OE,
    output logic       SRAM_WE_n,
    output logic       SRAM_OE_n,
    output logic       ADDR_INC,
    output logic [7:0] RD_DATA,
    output logic       RD_VALID,
    output logic       BUSY,
    output logic       ACQ_OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_SETUP, S_R_WAIT, S_INC
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       gnt_wr, gnt_wr_nxt;
    logic       gnt_acq, gnt_acq_nxt;

    logic       acq_pend, mcu_wr_pend, mcu_rd_pend;
    logic [7:0] acq_lat, mcu_lat;
    logic       acq_live, acq_drop;
    logic       acq_take, mcu_wr_take, mcu_rd_take;

    logic       we_n_nxt, oe_n_nxt, dq_oe_nxt, addr_inc_nxt, rd_valid_nxt;

    // An abort in the grant cycle must stop the write, so it masks the pending bit.
    assign acq_live    = acq_pend && !ACQ_ABORT;
    assign acq_take    = (state == S_W_SETUP) && gnt_acq;
    assign mcu_wr_take = (state == S_W_SETUP) && !gnt_acq;
    assign mcu_rd_take = (state == S_R_SETUP);

    assign BUSY = (state != S_IDLE) || acq_pend || mcu_wr_pend || mcu_rd_pend;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gnt_wr_nxt  = gnt_wr;
        gnt_acq_nxt = gnt_acq;
        acq_drop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (acq_live && SRAM_FULL) begin
                    acq_drop = 1'b1;
                end else if (acq_live) begin
                    state_nxt   = S_W_SETUP;
                    gnt_wr_nxt  = 1'b1;
                    gnt_acq_nxt = 1'b1;
                end else if (mcu_wr_pend) begin
                    state_nxt   = S_W_SETUP;
                    gnt_wr_nxt  = 1'b1;
                    gnt_acq_nxt = 1'b0;
                end else if (mcu_rd_pend) begin
                    state_nxt   = S_R_SETUP;
                    gnt_wr_nxt  = 1'b0;
                    gnt_acq_nxt = 1'b0;
                end
            end
            S_W_SETUP: begin
                state_nxt = S_W_PULSE;
                cnt_nxt   = 4'(WE_CYCLES - 1);
            end
            S_W_PULSE: begin
                if (cnt == 4'd0) state_nxt = S_W_HOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_W_HOLD:  state_nxt = S_INC;
            S_R_SETUP: begin
                state_nxt = S_R_WAIT;
                cnt_nxt   = 4'(RD_CYCLES - 1);
            end
            S_R_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_INC;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_INC:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered with it.
        we_n_nxt     = (state_nxt != S_W_PULSE);
        dq_oe_nxt    = (state_nxt == S_W_PULSE) || (state_nxt == S_W_HOLD);
        oe_n_nxt     = (state_nxt == S_W_SETUP) || (state_nxt == S_W_PULSE) ||
                       (state_nxt == S_W_HOLD)  || ((state_nxt == S_INC) && gnt_wr_nxt);
        addr_inc_nxt = (state_nxt == S_INC);
        rd_valid_nxt = (state_nxt == S_INC) && !gnt_wr_nxt;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            gnt_wr      <= 1'b0;
            gnt_acq     <= 1'b0;
            acq_pend    <= 1'b0;
            mcu_wr_pend <= 1'b0;
            mcu_rd_pend <= 1'b0;
            acq_lat     <= 8'h00;
            mcu_lat     <= 8'h00;
            SRAM_WE_n   <= 1'b1;
            SRAM_OE_n   <= 1'b0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_DQ_OUT <= 8'h00;
            ADDR_INC    <= 1'b0;
            RD_VALID    <= 1'b0;
            RD_DATA     <= 8'h00;
            ACQ_OVERRUN <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gnt_wr     <= gnt_wr_nxt;
            gnt_acq    <= gnt_acq_nxt;
            SRAM_WE_n  <= we_n_nxt;
            SRAM_OE_n  <= oe_n_nxt;
            SRAM_DQ_OE <= dq_oe_nxt;
            ADDR_INC   <= addr_inc_nxt;
            RD_VALID   <= rd_valid_nxt;

            if (state == S_W_SETUP)
                SRAM_DQ_OUT <= gnt_acq ? acq_lat : mcu_lat;
            if ((state == S_R_WAIT) && (cnt == 4'd0))
                RD_DATA <= SRAM_DQ_IN;

            // A request landing in the consume cycle is a fresh byte, not an overrun:
            // the old latch value is copied to DQ_OUT on the same edge.
            if (ACQ_ABORT) begin
                acq_pend <= 1'b0;
            end else if (ACQ_WR_REQ) begin
                acq_lat  <= ACQ_WR_DATA;
                acq_pend <= 1'b1;
                if (acq_pend && !acq_take && !acq_drop)
                    ACQ_OVERRUN <= 1'b1;
            end else if (acq_take || acq_drop) begin
                acq_pend <= 1'b0;
            end
            if (acq_drop)
                ACQ_OVERRUN <= 1'b1;

            if (MCU_WR_REQ) begin
                mcu_lat     <= MCU_WR_DATA;
                mcu_wr_pend <= 1'b1;
            end else if (mcu_wr_take) begin
                mcu_wr_pend <= 1'b0;
            end

            if (MCU_RD_REQ)
                mcu_rd_pend <= 1'b1;
            else if (mcu_rd_take)
                mcu_rd_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Testbench for sram_access_sequencer: directed timing checks, arbitration order,
// overrun/full/reset cases, and randomized request mixes against an SRAM model
// plus an in-order reference of expected writes, reads and increments.
module tb_sram_access_sequencer;

    localparam int WE = 2;
    localparam int RD = 2;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       ACQ_WR_REQ = 1'b0;
    logic [7:0] ACQ_WR_DATA = 8'h00;
    logic       ACQ_ABORT = 1'b0;
    logic       MCU_WR_REQ = 1'b0;
    logic [7:0] MCU_WR_DATA = 8'h00;
    logic       MCU_RD_REQ = 1'b0;
    logic       SRAM_FULL = 1'b0;
    logic [7:0] SRAM_DQ_IN;
    logic [7:0] SRAM_DQ_OUT;
    logic       SRAM_DQ_OE, SRAM_WE_n, SRAM_OE_n, ADDR_INC;
    logic [7:0] RD_DATA;
    logic       RD_VALID, BUSY, ACQ_OVERRUN;

    sram_access_sequencer #(.WE_CYCLES(WE), .RD_CYCLES(RD)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ACQ_WR_REQ(ACQ_WR_REQ), .ACQ_WR_DATA(ACQ_WR_DATA), .ACQ_ABORT(ACQ_ABORT),
        .MCU_WR_REQ(MCU_WR_REQ), .MCU_WR_DATA(MCU_WR_DATA), .MCU_RD_REQ(MCU_RD_REQ),
        .SRAM_FULL(SRAM_FULL), .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_WE_n(SRAM_WE_n), .SRAM_OE_n(SRAM_OE_n),
        .ADDR_INC(ADDR_INC), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .BUSY(BUSY), .ACQ_OVERRUN(ACQ_OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM + address counter model, updated mid-cycle
    logic [7:0] mem [0:255];
    logic [7:0] wr_log [0:1023];
    logic [7:0] addr = 8'h00;
    int         wr_n = 0;
    int         inc_cnt = 0;
    int         rv_cnt = 0;
    logic       prev_we = 1'b1;
    logic       prev_inc = 1'b0;
    logic       pl_req = 1'b0;
    logic [7:0] pl_val = 8'h00;
    logic       clr_req = 1'b0;
    logic       inv_ok;

    assign SRAM_DQ_IN = (!SRAM_OE_n) ? mem[addr] : 8'hEE;
    assign inv_ok = (SRAM_WE_n || (SRAM_OE_n && SRAM_DQ_OE)) &&
                    (!SRAM_DQ_OE || SRAM_OE_n) && !(ADDR_INC && prev_inc);

    always @(negedge CLOCK) begin
        chk("invariant", 32'(inv_ok), 32'd1);
        prev_we  <= SRAM_WE_n;
        prev_inc <= ADDR_INC;
        if (clr_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            addr <= 8'h00;
        end else begin
            if (pl_req) mem[addr] <= pl_val;
            if (!SRAM_WE_n && prev_we) begin
                wr_log[wr_n[9:0]] <= SRAM_DQ_OUT;
                wr_n <= wr_n + 1;
                mem[addr] <= SRAM_DQ_OUT;
            end
            if (ADDR_INC) begin
                addr    <= addr + 8'd1;
                inc_cnt <= inc_cnt + 1;
            end
        end
        if (RD_VALID) rv_cnt <= rv_cnt + 1;
    end

    // reference memory contents and address, advanced per expected access
    logic [7:0] ref_mem [0:255];
    logic [7:0] ref_addr = 8'h00;

    task automatic next_cycle();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clear_pulses();
        ACQ_WR_REQ = 1'b0;
        ACQ_ABORT  = 1'b0;
        MCU_WR_REQ = 1'b0;
        MCU_RD_REQ = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (BUSY && k < 100) begin
            next_cycle();
            k++;
        end
        chk(tag, 32'(k < 100), 32'd1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clear_pulses();
        next_cycle();
        next_cycle();
        chk("rst_we_n", 32'(SRAM_WE_n), 32'd1);
        chk("rst_oe_n", 32'(SRAM_OE_n), 32'd0);
        chk("rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
        chk("rst_addr_inc", 32'(ADDR_INC), 32'd0);
        chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
        chk("rst_rd_data", 32'(RD_DATA), 32'h00);
        chk("rst_dq_out", 32'(SRAM_DQ_OUT), 32'h00);
        chk("rst_overrun", 32'(ACQ_OVERRUN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        next_cycle();
    endtask

    // Requests issued together are served ACQ write, MCU write, MCU read; an abort
    // in the same cycle cancels the ACQ write.
    task automatic do_txn(input logic [2:0] mask, input logic abort,
                          input logic [7:0] ad, input logic [7:0] md);
        int wr0, inc0, rv0, nwr;
        logic [9:0] idx;
        wr0 = wr_n; inc0 = inc_cnt; rv0 = rv_cnt; nwr = 0;
        ACQ_WR_REQ = mask[0]; ACQ_WR_DATA = ad; ACQ_ABORT = abort;
        MCU_WR_REQ = mask[1]; MCU_WR_DATA = md; MCU_RD_REQ = mask[2];
        next_cycle();
        clear_pulses();
        wait_idle("txn_timeout");
        if (mask[0] && !abort) begin
            idx = 10'(wr0 + nwr);
            chk("txn_acq_byte", 32'(wr_log[idx]), 32'(ad));
            ref_mem[ref_addr] = ad;
            ref_addr = ref_addr + 8'd1;
            nwr++;
        end
        if (mask[1]) begin
            idx = 10'(wr0 + nwr);
            chk("txn_mcu_byte", 32'(wr_log[idx]), 32'(md));
            ref_mem[ref_addr] = md;
            ref_addr = ref_addr + 8'd1;
            nwr++;
        end
        if (mask[2]) begin
            chk("txn_rd_data", 32'(RD_DATA), 32'(ref_mem[ref_addr]));
            ref_addr = ref_addr + 8'd1;
        end
        chk("txn_wr_count", 32'(wr_n - wr0), 32'(nwr));
        chk("txn_inc_count", 32'(inc_cnt - inc0), 32'(nwr + int'(mask[2])));
        chk("txn_rv_count", 32'(rv_cnt - rv0), 32'(mask[2]));
        chk("txn_addr", 32'(addr), 32'(ref_addr));
    endtask

    initial begin
        int wr0, inc0;
        logic [9:0] idx;
        do_reset();

        // single MCU write: timing relative to the request cycle
        MCU_WR_REQ = 1'b1; MCU_WR_DATA = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            chk("t1_we_n", 32'(SRAM_WE_n), 32'(!(i >= 3 && i < 3 + WE)));
            chk("t1_dq_oe", 32'(SRAM_DQ_OE), 32'(i >= 3 && i <= 3 + WE));
            if (i >= 3 && i <= 3 + WE) chk("t1_dq_out", 32'(SRAM_DQ_OUT), 32'hA5);
            chk("t1_addr_inc", 32'(ADDR_INC), 32'(i == 4 + WE));
            next_cycle();
            clear_pulses();
        end

        // single MCU read of a preloaded byte
        pl_val = 8'h3C; pl_req = 1'b1;
        next_cycle();
        pl_req = 1'b0;
        MCU_RD_REQ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2 && i < 2 + RD) chk("t2_oe_n", 32'(SRAM_OE_n), 32'd0);
            chk("t2_rd_valid", 32'(RD_VALID), 32'(i == 3 + RD));
            chk("t2_addr_inc", 32'(ADDR_INC), 32'(i == 3 + RD));
            if (i == 3 + RD) chk("t2_rd_data", 32'(RD_DATA), 32'h3C);
            next_cycle();
            clear_pulses();
        end
        chk("t2_rd_hold", 32'(RD_DATA), 32'h3C);

        // reset in the middle of the write pulse
        inc0 = inc_cnt;
        MCU_WR_REQ = 1'b1; MCU_WR_DATA = 8'h77;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            clear_pulses();
        end
        chk("t6_in_pulse", 32'(SRAM_WE_n), 32'd0);
        RESET = 1'b1;
        next_cycle();
        chk("t6_we_n", 32'(SRAM_WE_n), 32'd1);
        chk("t6_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
        chk("t6_addr_inc", 32'(ADDR_INC), 32'd0);
        chk("t6_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        chk("t6_no_inc", 32'(inc_cnt - inc0), 32'd0);

        // known SRAM contents from here on
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        ref_addr = 8'h00;

        // three requesters in the same cycle
        do_txn(3'b111, 1'b0, 8'h11, 8'h22);

        // two acquisition bytes in consecutive cycles: first is lost
        wr0 = wr_n; inc0 = inc_cnt;
        ACQ_WR_REQ = 1'b1; ACQ_WR_DATA = 8'h44;
        next_cycle();
        ACQ_WR_DATA = 8'h55;
        next_cycle();
        clear_pulses();
        wait_idle("t4_timeout");
        idx = 10'(wr0);
        chk("t4_wr_count", 32'(wr_n - wr0), 32'd1);
        chk("t4_byte", 32'(wr_log[idx]), 32'h55);
        chk("t4_inc_count", 32'(inc_cnt - inc0), 32'd1);
        chk("t4_overrun", 32'(ACQ_OVERRUN), 32'd1);
        ref_mem[ref_addr] = 8'h55;
        ref_addr = ref_addr + 8'd1;
        do_txn(3'b010, 1'b0, 8'h00, 8'h66);
        chk("t4_overrun_sticky", 32'(ACQ_OVERRUN), 32'd1);
        RESET = 1'b1;
        next_cycle();
        RESET = 1'b0;
        chk("t4_overrun_clr", 32'(ACQ_OVERRUN), 32'd0);
        next_cycle();

        // SRAM full: acquisition dropped, MCU write still proceeds
        SRAM_FULL = 1'b1;
        wr0 = wr_n; inc0 = inc_cnt;
        ACQ_WR_REQ = 1'b1; ACQ_WR_DATA = 8'h99;
        next_cycle();
        clear_pulses();
        wait_idle("t5_timeout");
        for (int i = 0; i < 8; i++) next_cycle();
        chk("t5_no_write", 32'(wr_n - wr0), 32'd0);
        chk("t5_no_inc", 32'(inc_cnt - inc0), 32'd0);
        chk("t5_overrun", 32'(ACQ_OVERRUN), 32'd1);
        do_txn(3'b010, 1'b0, 8'h00, 8'hC3);
        SRAM_FULL = 1'b0;

        // randomized request mixes
        for (int t = 0; t < 150; t++) begin
            do_txn(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                   8'($urandom), 8'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) next_cycle();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
